picomips_sequencer: RTL and testbench

PICOMIPS_SEQUENCER -- requirements
Module: picomips_sequencer

---
 rtl/picomips_sequencer_if.sv | 36 +++
 rtl/picomips_sequencer.sv | 133 +++++++++++++
 tb/tb_picomips_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/picomips_sequencer_if.sv
// Bus between the picoMIPS sequencer and its ROM / datapath: instruction fetch,
// the handshake switch, and all decoded control outputs.
interface picomips_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int PMEM_WIDTH = 5,
  parameter int INST_WIDTH = 6
) ();
  localparam int IW = INST_WIDTH + 2 * ADDR_WIDTH + DATA_WIDTH;

  logic [IW-1:0]         instr;
  logic                  sw8;
  logic [PMEM_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] rs_addr;
  logic [ADDR_WIDTH-1:0] rt_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] imm;
  logic                  alu_mul;
  logic                  alu_b_imm;
  logic [1:0]            wr_src;
  logic                  reg_we;
  logic                  led_we;
  logic                  waiting;

  modport master (
    input  instr, sw8,
    output pc, rs_addr, rt_addr, rd_addr, imm, alu_mul, alu_b_imm,
           wr_src, reg_we, led_we, waiting
  );

  modport slave (
    output instr, sw8,
    input  pc, rs_addr, rt_addr, rd_addr, imm, alu_mul, alu_b_imm,
           wr_src, reg_we, led_we, waiting
  );
endinterface

// File: rtl/picomips_sequencer.sv
// picoMIPS instruction sequencer: pc, RUN/WAIT handshake FSM on a synchronised
// switch, and combinational decode of the current instruction word.
module picomips_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int PMEM_WIDTH = 5,
  parameter int INST_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  nReset,
  picomips_sequencer_if.master  bus
);
  localparam int IW     = INST_WIDTH + 2 * ADDR_WIDTH + DATA_WIDTH;
  localparam int OP_MSB = IW - 1;
  localparam int RS_MSB = IW - INST_WIDTH - 1;
  localparam int RD_MSB = DATA_WIDTH + ADDR_WIDTH - 1;

  typedef enum logic {ST_RUN, ST_WAIT} state_e;

  typedef enum logic [INST_WIDTH-1:0] {
    OP_ADD = INST_WIDTH'(0),
    OP_ADI = INST_WIDTH'(1),
    OP_MUL = INST_WIDTH'(2),
    OP_MLI = INST_WIDTH'(3),
    OP_NXX = INST_WIDTH'(4),
    OP_LXX = INST_WIDTH'(5)
  } opcode_e;

  state_e                state_q, state_d;
  logic [PMEM_WIDTH-1:0] pc_q, pc_d;
  logic                  sw_meta_q, sw_meta_d;
  logic                  sw_s_q, sw_s_d;

  logic [INST_WIDTH-1:0] op_fld;
  logic [ADDR_WIDTH-1:0] rs_fld, rd_fld;
  logic                  wr, led, is_wait, pol, advance;

  assign op_fld = bus.instr[OP_MSB -: INST_WIDTH];
  assign rs_fld = bus.instr[RS_MSB -: ADDR_WIDTH];
  assign rd_fld = bus.instr[RD_MSB -: ADDR_WIDTH];

  assign bus.rs_addr = rs_fld;
  assign bus.rt_addr = bus.instr[ADDR_WIDTH-1:0];
  assign bus.imm     = bus.instr[DATA_WIDTH-1:0];
  assign bus.pc      = pc_q;

  assign sw_meta_d = bus.sw8;
  assign sw_s_d    = sw_meta_q;

  always_comb begin
    wr            = 1'b0;
    led           = 1'b0;
    is_wait       = 1'b0;
    pol           = 1'b0;
    bus.alu_mul   = 1'b0;
    bus.alu_b_imm = 1'b0;
    bus.wr_src    = 2'b00;
    bus.rd_addr   = rd_fld;
    case (op_fld)
      OP_ADD: wr = 1'b1;
      OP_ADI: begin
        wr            = 1'b1;
        bus.alu_b_imm = 1'b1;
      end
      OP_MUL: begin
        wr          = 1'b1;
        bus.alu_mul = 1'b1;
      end
      OP_MLI: begin
        wr            = 1'b1;
        bus.alu_mul   = 1'b1;
        bus.alu_b_imm = 1'b1;
      end
      OP_NXX: begin
        is_wait = bus.instr[RS_MSB-1];
        pol     = bus.instr[RS_MSB-2];
      end
      OP_LXX: begin
        // Loads and LED take their register from the rs field.
        bus.rd_addr = rs_fld;
        if (bus.instr[RD_MSB]) begin
          is_wait = 1'b1;
          led     = 1'b1;
          pol     = bus.instr[RD_MSB-1];
        end else begin
          wr         = 1'b1;
          bus.wr_src = bus.instr[RD_MSB-1] ? 2'b10 : 2'b01;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    bus.reg_we  = 1'b0;
    bus.led_we  = 1'b0;
    bus.waiting = 1'b0;
    advance     = !is_wait || (sw_s_q == pol);
    if (advance) begin
      pc_d    = pc_q + PMEM_WIDTH'(1);
      state_d = ST_RUN;
    end else begin
      state_d = ST_WAIT;
    end
    if (state_q == ST_RUN) begin
      bus.reg_we = wr;
      bus.led_we = led;
    end else begin
      bus.waiting = 1'b1;
    end
    if (!nReset) begin
      bus.reg_we  = 1'b0;
      bus.led_we  = 1'b0;
      bus.waiting = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      pc_q      <= '0;
      state_q   <= ST_RUN;
      sw_meta_q <= 1'b0;
      sw_s_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      state_q   <= state_d;
      sw_meta_q <= sw_meta_d;
      sw_s_q    <= sw_s_d;
    end
  end
endmodule

// File: tb/tb_picomips_sequencer.sv
// Directed bench for picomips_sequencer: a small program ROM, a behavioural
// model checked every cycle, plus hand-computed literal expectations.
module tb_picomips_sequencer;
  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic sw8 = 1'b0;
  always #5 clk = ~clk;

  picomips_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .PMEM_WIDTH(5), .INST_WIDTH(6)) bus ();
  picomips_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .PMEM_WIDTH(5), .INST_WIDTH(6)) dut (
    .clk(clk), .nReset(nReset), .bus(bus)
  );

  logic [23:0] rom [32];
  assign bus.instr = rom[bus.pc];
  assign bus.sw8   = sw8;

  int vectors = 0;
  int miscompares = 0;
  int led_pulses = 0;

  function automatic logic [23:0] enc(int op, int rs, int rd, int low);
    return 24'((op << 18) | (rs << 13) | (rd << 8) | low);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What an instruction word should do, from the opcode table.
  function automatic void expect_of(input int w, output int wr, output int led, output int wt,
                                    output int pol, output int src, output int bimm,
                                    output int mul, output int rd);
    int op, rsf, rdf;
    op   = w / (1 << 18);
    rsf  = (w / (1 << 13)) % 32;
    rdf  = (w / (1 << 8)) % 32;
    wr = 0; led = 0; wt = 0; pol = 0; src = 0; bimm = 0; mul = 0; rd = rdf;
    if (op <= 3) begin
      wr   = 1;
      bimm = (op == 1 || op == 3) ? 1 : 0;
      mul  = (op >= 2) ? 1 : 0;
    end else if (op == 4) begin
      wt  = (rsf / 8) % 2;
      pol = (rsf / 4) % 2;
    end else if (op == 5) begin
      rd = rsf;
      if (rdf >= 16) begin
        wt = 1; led = 1; pol = (rdf / 8) % 2;
      end else begin
        wr = 1; src = ((rdf / 8) % 2) ? 2 : 1;
      end
    end
  endfunction

  int m_pc = 0;
  int m_stalled = 0;
  int m_s1 = 0, m_s2 = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin : model
    int wr, led, wt, pol, src, bimm, mul, rd;
    if (!nReset) begin
      m_pc = 0; m_stalled = 0; m_s1 = 0; m_s2 = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      expect_of(int'(rom[m_pc]), wr, led, wt, pol, src, bimm, mul, rd);
      if (wt != 0 && m_s2 != pol) m_stalled = 1;
      else begin
        m_pc = (m_pc + 1) % 32;
        m_stalled = 0;
      end
      m_s2 = m_s1;
      m_s1 = int'(sw8);
    end
  end

  always @(negedge clk) begin : compare
    int wr, led, wt, pol, src, bimm, mul, rd, active, w;
    if (m_valid) begin
      w = int'(rom[m_pc]);
      expect_of(w, wr, led, wt, pol, src, bimm, mul, rd);
      active = (nReset && m_stalled == 0) ? 1 : 0;
      check("pc", 32'(bus.pc), 32'(m_pc));
      check("reg_we", 32'(bus.reg_we), 32'(active & wr));
      check("led_we", 32'(bus.led_we), 32'(active & led));
      check("waiting", 32'(bus.waiting), 32'((nReset && m_stalled != 0) ? 1 : 0));
      if (nReset) begin
        check("rs_addr", 32'(bus.rs_addr), 32'((w / (1 << 13)) % 32));
        check("rt_addr", 32'(bus.rt_addr), 32'(w % 32));
        check("rd_addr", 32'(bus.rd_addr), 32'(rd));
        check("imm", 32'(bus.imm), 32'(w % 256));
      end
      if (active != 0 && wr != 0) begin
        check("wr_src", 32'(bus.wr_src), 32'(src));
        check("alu_b_imm", 32'(bus.alu_b_imm), 32'(bimm));
        check("alu_mul", 32'(bus.alu_mul), 32'(mul));
      end
      if (bus.led_we === 1'b1) led_pulses++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input int target, input int budget, input string name);
    for (int i = 0; i < budget && int'(bus.pc) != target; i++) step(1);
    check(name, 32'(bus.pc), 32'(target));
  endtask

  initial begin
    for (int i = 10; i < 32; i++) begin
      case (i % 3)
        0:       rom[i] = enc(0, i % 8, (i + 1) % 32, i % 32);
        1:       rom[i] = enc(1, i % 8, (i + 2) % 32, i);
        default: rom[i] = enc(3, i % 8, (i + 3) % 32, 255 - i);
      endcase
    end
    rom[0]  = enc(1, 0, 1, 8'h05);
    rom[1]  = enc(2, 1, 2, 8'h01);
    rom[2]  = enc(5, 3, 0, 8'h7F);
    rom[3]  = enc(4, 5'b01000, 0, 0);
    rom[4]  = enc(5, 4, 5'b11000, 0);
    rom[5]  = enc(4, 5'b01100, 0, 0);
    rom[6]  = enc(5, 6, 5'b01000, 0);
    rom[7]  = enc(6'h3F, 1, 2, 3);
    rom[8]  = enc(4, 5'b00100, 0, 0);
    rom[9]  = enc(5, 9, 5'b10000, 0);
    rom[31] = enc(0, 6, 7, 5);

    nReset = 1'b0; sw8 = 1'b0;
    step(2);
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_reg_we", 32'(bus.reg_we), 32'd0);
    check("rst_waiting", 32'(bus.waiting), 32'd0);
    nReset = 1'b1;
    #1;
    check("p0_pc", 32'(bus.pc), 32'd0);
    check("p0_reg_we", 32'(bus.reg_we), 32'd1);
    check("p0_wr_src", 32'(bus.wr_src), 32'd0);
    check("p0_alu_mul", 32'(bus.alu_mul), 32'd0);
    check("p0_imm", 32'(bus.imm), 32'h05);
    step(1);
    check("p1_pc", 32'(bus.pc), 32'd1);
    check("p1_alu_mul", 32'(bus.alu_mul), 32'd1);
    check("p1_reg_we", 32'(bus.reg_we), 32'd1);
    step(1);
    check("p2_pc", 32'(bus.pc), 32'd2);
    check("p2_wr_src", 32'(bus.wr_src), 32'd1);
    check("p2_imm", 32'(bus.imm), 32'h7F);
    check("p2_rd_addr", 32'(bus.rd_addr), 32'd3);
    step(1);
    check("nsw0_pc", 32'(bus.pc), 32'd3);
    led_pulses = 0;
    step(1);
    check("nsw0_advance", 32'(bus.pc), 32'd4);
    check("led_run_pulse", 32'(bus.led_we), 32'd1);
    check("led_run_waiting", 32'(bus.waiting), 32'd0);
    step(1);
    check("led_wait_waiting", 32'(bus.waiting), 32'd1);
    check("led_wait_led_we", 32'(bus.led_we), 32'd0);
    step(2);
    check("led_hold_pc", 32'(bus.pc), 32'd4);
    sw8 = 1'b1;
    step(2);
    check("sync_hold_pc", 32'(bus.pc), 32'd4);
    step(1);
    check("sync_release_pc", 32'(bus.pc), 32'd5);
    check("release_waiting", 32'(bus.waiting), 32'd0);
    check("led_single_pulse", 32'(led_pulses), 32'd1);
    step(1);
    check("lds_pc", 32'(bus.pc), 32'd6);
    check("lds_wr_src", 32'(bus.wr_src), 32'd2);
    check("lds_rd_addr", 32'(bus.rd_addr), 32'd6);
    step(1);
    check("nop3f_reg_we", 32'(bus.reg_we), 32'd0);
    check("nop3f_led_we", 32'(bus.led_we), 32'd0);
    step(1);
    check("nop3f_advance", 32'(bus.pc), 32'd8);
    step(1);
    check("nxx_nop_advance", 32'(bus.pc), 32'd9);
    check("led0_pulse", 32'(bus.led_we), 32'd1);
    step(1);
    check("led0_waiting", 32'(bus.waiting), 32'd1);
    sw8 = 1'b0;
    wait_pc(10, 8, "led0_release");
    wait_pc(31, 40, "reach_pc31");
    check("pc31_reg_we", 32'(bus.reg_we), 32'd1);
    step(1);
    check("pc_wrap", 32'(bus.pc), 32'd0);
    wait_pc(4, 10, "second_led");
    step(1);
    check("second_wait", 32'(bus.waiting), 32'd1);
    nReset = 1'b0;
    #1;
    check("rst_in_wait_waiting", 32'(bus.waiting), 32'd0);
    check("rst_in_wait_reg_we", 32'(bus.reg_we), 32'd0);
    step(1);
    nReset = 1'b1;
    #1;
    check("rst_wait_pc", 32'(bus.pc), 32'd0);
    check("rst_wait_waiting", 32'(bus.waiting), 32'd0);
    step(1);
    check("rst_wait_run", 32'(bus.pc), 32'd1);
    step(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "timeout");
  end
endmodule
